// File: rtl/blob_pkg.sv
// blob_pkg: shared frame geometry, state type and counter-width helper for blob_seq_tx
package blob_pkg;
   localparam int IMG_ROW = 600;
   localparam int IMG_COL = 800;
   localparam int BLOB_CNT_W = 8;
   function automatic int cnt_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
   localparam int ROW_W = cnt_w(IMG_ROW);
   localparam int COL_W = cnt_w(IMG_COL);
   typedef enum logic [2:0] {IDLE, ARMED, STREAM, FLUSH, WAIT} blob_tx_state_t;
endpackage

// File: rtl/blob_binarize.sv
// blob_binarize: threshold compare of the grey stream into a one-bit foreground stream
// Optional 3-tap horizontal majority window: define BLOB_TX_MAJORITY_EN
module blob_binarize #(
   parameter int PIX_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             kill,
   input  logic [PIX_W-1:0] thr,
   input  logic             pix_valid,
   input  logic [PIX_W-1:0] pix,
   input  logic             col_last,
   output logic             seq_valid,
   output logic             seq,
   output logic             pend
);
   logic bit_in;
   assign bit_in = pix >= thr;
`ifdef BLOB_TX_MAJORITY_EN
   logic b_prev, b_cur, cur_last, emit, nxt;
   // A pending pixel is emitted once its right neighbour arrives, or at once if it ends the row
   always_comb begin
      emit = pend && (cur_last || pix_valid);
      nxt = cur_last ? 1'b0 : bit_in;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         seq_valid <= 1'b0;
         seq <= 1'b0;
         pend <= 1'b0;
         b_prev <= 1'b0;
         b_cur <= 1'b0;
         cur_last <= 1'b0;
      end else if (kill) begin
         seq_valid <= 1'b0;
         pend <= 1'b0;
      end else begin
         seq_valid <= emit;
         if (emit) seq <= (b_prev & b_cur) | (b_prev & nxt) | (b_cur & nxt);
         if (pix_valid) begin
            b_prev <= (pend && !cur_last) ? b_cur : 1'b0;
            b_cur <= bit_in;
            cur_last <= col_last;
            pend <= 1'b1;
         end else if (emit) pend <= 1'b0;
      end
`else
   logic unused_col_last;
   assign unused_col_last = col_last;
   assign pend = 1'b0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         seq_valid <= 1'b0;
         seq <= 1'b0;
      end else begin
         seq_valid <= pix_valid && !kill;
         if (pix_valid) seq <= bit_in;
      end
`endif
endmodule

// File: rtl/blob_seq_tx.sv
// blob_seq_tx: frames one binarised raster into the blob pipeline and collects its count
// Optional majority filter in blob_binarize: define BLOB_TX_MAJORITY_EN
module blob_seq_tx #(
   parameter int IMG_ROW = blob_pkg::IMG_ROW,
   parameter int IMG_COL = blob_pkg::IMG_COL,
   parameter int PIX_W = 12,
   parameter int FLUSH_CYCLES = 200,
   parameter int RESULT_TIMEOUT = 300000
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [PIX_W-1:0] i_threshold,
   input  logic             i_pix_valid,
   input  logic             i_sof,
   input  logic [PIX_W-1:0] i_pix_gray,
   output logic             o_valid,
   output logic             o_data_valid,
   output logic             o_seq,
   output logic             o_proc_ccd,
   input  logic             i_blob_valid,
   input  logic [7:0]       i_blob_count,
   output logic [7:0]       o_count,
   output logic             o_done,
   output logic             o_err,
   output logic             o_busy
);
   import blob_pkg::*;
   localparam int RW = cnt_w(IMG_ROW);
   localparam int CW = cnt_w(IMG_COL);
   localparam int FW = cnt_w(FLUSH_CYCLES);
   localparam int TW = cnt_w(RESULT_TIMEOUT);
   blob_tx_state_t state;
   logic [RW-1:0] row;
   logic [CW-1:0] col;
   logic [FW-1:0] fc;
   logic [TW-1:0] tc;
   logic [PIX_W-1:0] thr;
   logic acc, abort, col_end, last, pend;
   always_comb begin
      acc = i_pix_valid && (state == ARMED ? i_sof : state == STREAM && !i_sof);
      abort = state == STREAM && i_pix_valid && i_sof;
      col_end = col == CW'(IMG_COL - 1);
      last = acc && col_end && row == RW'(IMG_ROW - 1);
   end
   assign o_busy = state != IDLE;
   blob_binarize #(.PIX_W(PIX_W)) u_bin (
      .clk(i_clk),
      .rst_n(i_rst_n),
      .kill(abort),
      .thr(thr),
      .pix_valid(acc),
      .pix(i_pix_gray),
      .col_last(col_end),
      .seq_valid(o_data_valid),
      .seq(o_seq),
      .pend(pend)
   );
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state <= IDLE;
         row <= '0;
         col <= '0;
         fc <= '0;
         tc <= '0;
         thr <= '0;
         o_valid <= 1'b0;
         o_proc_ccd <= 1'b0;
         o_count <= '0;
         o_done <= 1'b0;
         o_err <= 1'b0;
      end else begin
         o_done <= 1'b0;
         o_err <= 1'b0;
         if (acc) begin
            col <= col_end ? '0 : col + 1'b1;
            if (col_end) row <= row + 1'b1;
         end
         case (state)
            IDLE: if (i_start) begin
               thr <= i_threshold;
               row <= '0;
               col <= '0;
               o_valid <= 1'b1;
               o_proc_ccd <= 1'b1;
               state <= ARMED;
            end
            ARMED: if (acc) state <= last ? FLUSH : STREAM;
            STREAM: if (abort) begin
               o_valid <= 1'b0;
               o_proc_ccd <= 1'b0;
               o_done <= 1'b1;
               o_err <= 1'b1;
               state <= IDLE;
            end else if (last) state <= FLUSH;
            // Flush length is measured from the last data-valid cycle, so hold while the filter drains
            FLUSH: if (o_data_valid || pend) fc <= '0;
            else if (fc == FW'(FLUSH_CYCLES - 1)) begin
               o_valid <= 1'b0;
               tc <= '0;
               state <= WAIT;
            end else fc <= fc + 1'b1;
            WAIT: if (i_blob_valid) begin
               o_count <= i_blob_count;
               o_done <= 1'b1;
               o_proc_ccd <= 1'b0;
               state <= IDLE;
            end else if (tc == TW'(RESULT_TIMEOUT - 1)) begin
               o_count <= 8'hFF;
               o_done <= 1'b1;
               o_err <= 1'b1;
               o_proc_ccd <= 1'b0;
               state <= IDLE;
            end else tc <= tc + 1'b1;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_blob_seq_tx.sv
// tb_blob_seq_tx: scoreboard bench for blob_seq_tx on a reduced raster
module tb_blob_seq_tx;
   localparam int R = 12, C = 16, N = R * C, F = 20, RT = 300;
`ifdef BLOB_TX_MAJORITY_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   logic clk = 0, rst_n = 0, start = 0, pix_valid = 0, sof = 0, blob_valid = 0;
   logic [11:0] threshold = 0, pix_gray = 0;
   logic [7:0] blob_count = 0;
   logic valid, data_valid, seq, proc_ccd, done, err, busy;
   logic [7:0] count;
   logic [11:0] img [N];
   bit exp_q [$];
   int checks = 0, errors = 0, cyc = 0, dv_cnt = 0, ones = 0, last_dv = 0, first_dv = -1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   blob_seq_tx #(.IMG_ROW(R), .IMG_COL(C), .PIX_W(12), .FLUSH_CYCLES(F), .RESULT_TIMEOUT(RT)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_threshold(threshold),
      .i_pix_valid(pix_valid), .i_sof(sof), .i_pix_gray(pix_gray),
      .o_valid(valid), .o_data_valid(data_valid), .o_seq(seq), .o_proc_ccd(proc_ccd),
      .i_blob_valid(blob_valid), .i_blob_count(blob_count),
      .o_count(count), .o_done(done), .o_err(err), .o_busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit raw(input int k, input logic [11:0] th);
      return img[k] >= th;
   endfunction

   function automatic bit model(input int k, input logic [11:0] th);
`ifdef BLOB_TX_MAJORITY_EN
      bit p, c, n;
      c = raw(k, th);
      p = (k % C != 0) && raw(k - 1, th);
      n = (k % C != C - 1) && raw(k + 1, th);
      return (p & c) | (p & n) | (c & n);
`else
      return raw(k, th);
`endif
   endfunction

   always @(negedge clk)
      if (rst_n && data_valid) begin
         dv_cnt++;
         ones += int'(seq);
         last_dv = cyc;
         if (first_dv < 0) first_dv = cyc;
         if (exp_q.size() == 0) check("dv_unexpected", 1, 0);
         else check("seq", seq, exp_q.pop_front());
      end

   task automatic start_frame(input logic [11:0] th);
      dv_cnt = 0;
      ones = 0;
      first_dv = -1;
      @(posedge clk); #1 start = 1; threshold = th;
      @(posedge clk); #1 start = 0; threshold = ~th;
   endtask

   task automatic stream(input logic [11:0] th, input int gap, input int abort_k, output int t0);
      t0 = 0;
      for (int k = 0; k < N; k++) begin
         @(posedge clk); #1;
         pix_valid = 1;
         pix_gray = img[k];
         sof = (k == 0) || (k == abort_k);
         start = (k == N / 2);
         threshold = 12'd0;
         if (k == 0) t0 = cyc;
         if (k == abort_k) begin
            @(posedge clk); #1 pix_valid = 0; sof = 0;
            return;
         end
         exp_q.push_back(model(k, th));
         if (k % C == C - 1)
            for (int g = 0; g < gap; g++) begin
               @(posedge clk); #1 pix_valid = 0; sof = 0; start = 0;
            end
      end
      @(posedge clk); #1 pix_valid = 0; sof = 0; start = 0;
   endtask

   task automatic wait_fall(output int t);
      t = -1;
      for (int i = 0; i < 2000 && t < 0; i++) begin
         @(negedge clk);
         if (!valid) t = cyc;
      end
      if (t < 0) check("valid_fall_timeout", 0, 1);
   endtask

   task automatic wait_done(output int t);
      t = -1;
      for (int i = 0; i < RT + 100 && t < 0; i++) begin
         @(negedge clk);
         if (done) t = cyc;
      end
      if (t < 0) check("done_timeout", 0, 1);
   endtask

   task automatic end_checks(input int t0, output int tf);
      wait_fall(tf);
      check("dv_count", dv_cnt, N);
      check("latency", first_dv - t0, LAT);
      check("flush_len", tf - last_dv, F + 1);
      check("q_empty", exp_q.size(), 0);
      check("wait_proc", proc_ccd, 1);
      check("wait_busy", busy, 1);
   endtask

   task automatic respond(input int wait_cyc, input logic [7:0] cnt);
      repeat (wait_cyc) @(posedge clk);
      #1 blob_valid = 1; blob_count = cnt;
      @(posedge clk); #1 blob_valid = 0; blob_count = 8'h55;
      @(negedge clk);
      check("done", done, 1);
      check("err", err, 0);
      check("count", count, cnt);
      check("proc_off", proc_ccd, 0);
      check("busy_off", busy, 0);
      @(negedge clk);
      check("done_pulse", done, 0);
      check("count_hold", count, cnt);
   endtask

   initial begin
      int t0, tf, td;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", valid, 0);
      check("rst_dv", data_valid, 0);
      check("rst_seq", seq, 0);
      check("rst_proc", proc_ccd, 0);
      check("rst_count", count, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);
      rst_n = 1;
      // gradient frame with row gaps, ignored i_blob_valid in ARMED and i_start in STREAM
      for (int k = 0; k < N; k++) img[k] = 12'((k * 37) % 4096);
      start_frame(12'd2048);
      @(negedge clk);
      check("armed_valid", valid, 1);
      check("armed_proc", proc_ccd, 1);
      check("armed_busy", busy, 1);
      @(posedge clk); #1 blob_valid = 1; blob_count = 8'd99;
      @(posedge clk); #1 blob_valid = 0;
      @(negedge clk);
      check("armed_ignore_bv", done, 0);
      check("armed_still", valid, 1);
      stream(12'd2048, 2, -1, t0);
      end_checks(t0, tf);
      respond(50, 8'd37);
      // timeout frame
      for (int k = 0; k < N; k++) img[k] = 12'((k * 91 + 7) % 4096);
      start_frame(12'd1000);
      stream(12'd1000, 0, -1, t0);
      end_checks(t0, tf);
      wait_done(td);
      check("timeout_at", td - tf, RT);
      check("timeout_err", err, 1);
      check("timeout_cnt", count, 8'hFF);
      @(negedge clk);
      check("timeout_idle", busy, 0);
      check("timeout_proc", proc_ccd, 0);
      // mid-frame abort at row 10 col 5
      for (int k = 0; k < N; k++) img[k] = 12'((k * 53) % 4096);
      start_frame(12'd2048);
      stream(12'd2048, 1, 10 * C + 5, t0);
      @(negedge clk);
      check("abort_done", done, 1);
      check("abort_err", err, 1);
      check("abort_valid", valid, 0);
      check("abort_proc", proc_ccd, 0);
      check("abort_dv", data_valid, 0);
      check("abort_count", count, 8'hFF);
      exp_q.delete();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1 pix_valid = 1; pix_gray = 12'hFFF;
      end
      @(posedge clk); #1 pix_valid = 0;
      repeat (5) @(negedge clk);
      check("abort_dv_total", dv_cnt, 10 * C + 6 - LAT);
      check("abort_idle", busy, 0);
      // isolated pixel and a run of three
      for (int k = 0; k < N; k++) img[k] = 12'd0;
      img[2 * C + 9] = 12'hFFF;
      for (int k = 3 * C + 4; k <= 3 * C + 6; k++) img[k] = 12'hFFF;
      start_frame(12'd2048);
      stream(12'd2048, 1, -1, t0);
      end_checks(t0, tf);
      check("ones", ones, LAT == 2 ? 3 : 4);
      respond(5, 8'd200);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/blob_seq_tx.md
Name: blob_seq_tx

Overview:
- Frame-level source for the blob-counting pipeline. Binarises the camera grey-scale pixel stream, frames exactly one IMG_ROW x IMG_COL raster, and drives the blob pipeline's valid, data-valid, process and sequence inputs.
- Holds processing active until the pipeline reports its count, then latches the count and signals completion.
- Sits between the CCD capture/grey conversion path and the blob pipeline.

Parameters:
- IMG_ROW, 600, frame rows.
- IMG_COL, 800, frame columns.
- PIX_W, 12, grey pixel width.
- FLUSH_CYCLES, 200, cycles o_valid stays high after the last pixel.
- RESULT_TIMEOUT, 300000, maximum cycles in WAIT before aborting.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle request to capture the next frame
- i_threshold  in  PIX_W  binarisation threshold, latched on accepted i_start
- i_pix_valid  in  1  grey pixel valid
- i_sof  in  1  qualifies the first pixel of a frame; meaningful only with i_pix_valid
- i_pix_gray  in  PIX_W  grey pixel
- o_valid  out  1  to blob i_valid
- o_data_valid  out  1  to blob i_data_valid
- o_seq  out  1  to blob i_seq; 1 = foreground
- o_proc_ccd  out  1  to blob i_proc_ccd
- i_blob_valid  in  1  blob o_valid
- i_blob_count  in  8  blob o_count
- o_count  out  8  latched blob count
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  qualifies o_done; 1 = abort or timeout
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous, active-low, on i_rst_n.
- Reset values: all outputs 0, state IDLE, counters 0, latched threshold 0. Reset asserted mid-frame drops o_valid, o_data_valid and o_proc_ccd asynchronously.
- States: IDLE, ARMED, STREAM, FLUSH, WAIT.
- IDLE: i_start latches i_threshold and goes to ARMED. i_start is ignored in every other state.
- ARMED: o_proc_ccd=1 and o_valid=1. Stay until i_pix_valid && i_sof. That pixel is pixel (0,0); go to STREAM.
- Pixel path: for every accepted pixel, o_seq = (i_pix_gray >= threshold) and o_data_valid=1, both registered one cycle after the input. Otherwise o_data_valid=0 and o_seq holds its value.
- Raster counters: col wraps at IMG_COL-1 and increments row. Pixels arrive in bursts; gaps without i_pix_valid do not advance the counters.
- STREAM to FLUSH: on the pixel at (IMG_ROW-1, IMG_COL-1); its o_data_valid pulse is still emitted.
- FLUSH: o_valid=1, o_data_valid=0, for FLUSH_CYCLES cycles after the last data-valid cycle. Then o_valid=0 and go to WAIT.
- WAIT: o_proc_ccd=1 and the timeout counter runs.
  - On i_blob_valid: o_count=i_blob_count, o_done=1, o_err=0, o_proc_ccd=0 in the same registered update; go to IDLE.
  - i_blob_valid arriving on the same cycle the timeout expires counts as success.
  - On timeout: o_count=8'hFF, o_done=1, o_err=1; go to IDLE.
- Mid-frame abort: i_sof with i_pix_valid in STREAM before the last pixel. Next cycle: o_valid=0, o_data_valid=0, o_proc_ccd=0, o_done=1, o_err=1, o_count unchanged; go to IDLE. The offending pixel is not emitted.
- Latency: o_data_valid trails i_pix_valid by 1 cycle, or 2 with the optional filter. Between ARMED and FLUSH end, the number of o_data_valid cycles is exactly IMG_ROW*IMG_COL.
- i_blob_valid outside WAIT is ignored.
- o_count keeps its last value until the next o_done.

Optional Feature:
- Macro: BLOB_TX_MAJORITY_EN.
- Defined: 3-tap horizontal majority filter on the binary stream. o_seq = majority(prev, cur, next). At col 0 and col IMG_COL-1 the out-of-row neighbour is treated as 0. Adds 1 cycle of latency.
- FLUSH starts after the filtered last pixel is emitted, so it is still emitted. Data-valid count is unchanged.
- Not defined: o_seq is the raw threshold compare.

Decomposition:
- Package blob_pkg:
  - IMG_ROW, IMG_COL, BLOB_CNT_W=8, the state enum blob_tx_state_t.
  - Row/column counter widths derived with $clog2.
- Sub-module blob_binarize: threshold compare plus the optional majority window, with a pixel-valid in/out handshake and a column-edge input. The top level owns the FSM, counters and timeout.

Test Plan:
- Full frame, gradient grey: i_start with threshold 2048, then 480000 pixels with a gap every row. Expect exactly 480000 o_data_valid pulses; o_seq=1 for grey>=2048; o_valid low 200 cycles after the last data-valid.
- Result handshake: in WAIT, pulse i_blob_valid with count 37 after 5000 cycles. Expect o_count=37, o_done for one cycle, o_err=0, o_proc_ccd low the next cycle, o_busy=0.
- Timeout: never assert i_blob_valid. Expect o_done with o_err=1 and o_count=8'hFF exactly RESULT_TIMEOUT cycles after WAIT entry.
- Mid-frame i_sof at row 10 col 5: expect an abort pulse (o_done=1, o_err=1); o_valid and o_proc_ccd are 0 the next cycle, and no further o_data_valid.
- i_start during STREAM and i_blob_valid during ARMED: both ignored; frame completes normally.
- With BLOB_TX_MAJORITY_EN, an isolated single foreground pixel at col 400: o_seq never goes to 1. A run of 3 ones: output 3 ones shifted by 1 extra cycle.
